// File: rtl/serial_frame_transmitter_if.sv
// Parallel-load handshake and serial-line bundle for serial_frame_transmitter.
`timescale 1ns/1ps
interface serial_frame_transmitter_if #(
    parameter int WIDTH = 4
);
    // Handshake: a word on I is taken on a rising edge where load=1 and ready=1.
    // load while ready=0 is dropped, not queued; ready, busy, tx, done and A are registered.
    logic [WIDTH-1:0] I;
    logic             load;
    logic             ready;
    logic             busy;
    logic             tx;
    logic             done;
    logic [WIDTH-1:0] A;

    modport master (output I, load, input ready, busy, tx, done, A);
    modport slave  (input I, load, output ready, busy, tx, done, A);
endinterface

// File: rtl/serial_frame_transmitter.sv
// Parallel-in, serial-out framer: start bit (0), WIDTH data bits LSB first, stop bit (1),
// each bit held BIT_CYCLES clocks, with a one-cycle done pulse after the stop bit.
`timescale 1ns/1ps
module serial_frame_transmitter #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        clear_n,
    serial_frame_transmitter_if.slave   bus,
    output logic [1:0]                  state_dbg
);
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] a_d;
    logic             tx_d, ready_d, busy_d, done_d;
    logic             bit_end;

    assign state_dbg = state_q;
    assign bit_end   = (cyc_q == CYC_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        a_d     = bus.A;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = START;
                    shift_d = bus.I;
                    a_d     = bus.I;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            bus.A     <= '0;
            bus.tx    <= 1'b1;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            bus.A     <= a_d;
            bus.tx    <= tx_d;
            bus.ready <= ready_d;
            bus.busy  <= busy_d;
            bus.done  <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Two transmitters (BIT_CYCLES 1 and 3) share clock and reset; a frame-level model
// expands each accepted word into per-cycle expectations that a monitor compares.
`timescale 1ns/1ps
module tb_serial_frame_transmitter;
    localparam int W       = 4;
    localparam int N_LANES = 2;
    localparam int LANE_BC [N_LANES] = '{1, 3};

    typedef struct packed {
        logic         tx;
        logic         busy;
        logic         ready;
        logic         done;
        logic [W-1:0] a;
    } exp_t;

    logic               clk = 1'b0;
    logic               clear_n = 1'b0;
    logic [N_LANES-1:0] drv_load;
    logic [W-1:0]       drv_i [N_LANES];
    logic [N_LANES-1:0] tx_w, busy_w, ready_w, done_w;
    logic [W-1:0]       a_w [N_LANES];
    logic [1:0]         dbg_w [N_LANES];

    exp_t               exp_q [N_LANES][$];
    logic [N_LANES-1:0] model_ready = '1;
    logic [W-1:0]       last_a [N_LANES];
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cyc = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < N_LANES; g++) begin : lane
        serial_frame_transmitter_if #(.WIDTH(W)) bus ();
        serial_frame_transmitter #(.WIDTH(W), .BIT_CYCLES(LANE_BC[g])) u_dut (
            .clk       (clk),
            .clear_n   (clear_n),
            .bus       (bus.slave),
            .state_dbg (dbg_w[g])
        );
        assign bus.I      = drv_i[g];
        assign bus.load   = drv_load[g];
        assign tx_w[g]    = bus.tx;
        assign busy_w[g]  = bus.busy;
        assign ready_w[g] = bus.ready;
        assign done_w[g]  = bus.done;
        assign a_w[g]     = bus.A;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int l, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d cycle %0d: got %h, expected %h", name, l, cyc, act, exp);
        end
    endtask

    // A frame is start bit, data LSB first, stop bit, each held BC cycles, then one done cycle.
    task automatic push_frame(input int l, input logic [W-1:0] w);
        exp_t e;
        logic bv;
        for (int b = 0; b < W + 2; b++) begin
            if (b == 0)          bv = 1'b0;
            else if (b == W + 1) bv = 1'b1;
            else                 bv = w[b-1];
            e = '{tx: bv, busy: 1'b1, ready: 1'b0, done: 1'b0, a: w};
            for (int k = 0; k < LANE_BC[l]; k++) exp_q[l].push_back(e);
        end
        e = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b1, a: w};
        exp_q[l].push_back(e);
    endtask

    // Model: a word is accepted on an edge where load is high and the previous cycle was ready.
    initial begin
        forever begin
            @(posedge clk);
            if (clear_n) begin
                for (int l = 0; l < N_LANES; l++) begin
                    if (model_ready[l] && drv_load[l]) push_frame(l, drv_i[l]);
                end
            end
        end
    end

    // Monitor: one expectation per lane per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        for (int l = 0; l < N_LANES; l++) last_a[l] = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int l = 0; l < N_LANES; l++) begin
                if (!clear_n) begin
                    exp_q[l].delete();
                    last_a[l] = '0;
                    e = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b0, a: '0};
                    // IDLE is reported as 0 on the debug port
                    check("state_dbg_in_reset", l, 8'(dbg_w[l]), 8'd0);
                end else if (exp_q[l].size() > 0) begin
                    e = exp_q[l].pop_front();
                end else begin
                    e = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b0, a: last_a[l]};
                end
                last_a[l]      = e.a;
                model_ready[l] = e.ready;
                check("tx",    l, 8'(tx_w[l]),    8'(e.tx));
                check("busy",  l, 8'(busy_w[l]),  8'(e.busy));
                check("ready", l, 8'(ready_w[l]), 8'(e.ready));
                check("done",  l, 8'(done_w[l]),  8'(e.done));
                check("A",     l, 8'(a_w[l]),     8'(e.a));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int l, input logic [W-1:0] w);
        drv_load[l] = 1'b1;
        drv_i[l]    = w;
        tick(1);
        drv_load[l] = 1'b0;
        drv_i[l]    = W'($urandom);
    endtask

    initial begin
        drv_load = '0;
        drv_i[0] = '0;
        drv_i[1] = '0;
        clear_n  = 1'b0;
        tick(3);
        clear_n = 1'b1;
        tick(2);

        // basic frame and stretched-bit frame
        send(0, 4'hA);
        tick(8);
        send(1, 4'h1);
        tick(22);

        // load during DATA of a 4'h3 frame is ignored
        send(0, 4'h3);
        tick(2);
        drv_load[0] = 1'b1;
        drv_i[0]    = 4'hF;
        tick(2);
        drv_load[0] = 1'b0;
        tick(8);

        // back-to-back: load held, word switched during the done cycle
        drv_load[0] = 1'b1;
        drv_i[0]    = 4'h5;
        tick(7);
        drv_i[0] = 4'hC;
        tick(1);
        drv_load[0] = 1'b0;
        tick(9);

        // I churns while a 4'h9 frame is in flight
        send(0, 4'h9);
        repeat (7) begin
            drv_i[0] = W'($urandom);
            tick(1);
        end
        tick(3);

        // a few stretched frames with random words
        repeat (3) begin
            send(1, W'($urandom));
            tick(20);
        end

        // asynchronous reset in the middle of DATA aborts the frame without done
        send(0, 4'hA);
        tick(2);
        #1 clear_n = 1'b0;
        tick(2);
        clear_n = 1'b1;
        tick(10);

        // random load pulses on both lanes
        repeat (300) begin
            for (int l = 0; l < N_LANES; l++) begin
                drv_load[l] = ($urandom_range(0, 3) == 0);
                drv_i[l]    = W'($urandom);
            end
            tick(1);
        end
        drv_load = '0;
        tick(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
